// File: rtl/instruction_fetch_stage.sv
// RV32I instruction fetch stage: owns the PC, addresses the ROM and fills the IF/ID register.
// Handles hazard stalls, EX redirects (flush) and sticky fetch-fault detection.
module instruction_fetch_stage #(
    parameter int unsigned            DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0]  RESET_PC     = 32'h00400000,
    parameter int unsigned            MEMORY_DEPTH = 64,
    parameter logic [DATA_WIDTH-1:0]  NOP_INSTR    = 32'h00000013
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_target_i,
    input  logic [DATA_WIDTH-1:0] instruction_i,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0] ifid_pc_o,
    output logic [DATA_WIDTH-1:0] ifid_pc_plus4_o,
    output logic [DATA_WIDTH-1:0] ifid_instruction_o,
    output logic                  ifid_valid_o,
    output logic                  fetch_fault_o,
    output logic [DATA_WIDTH-1:0] fetch_count_o
);

    typedef enum logic {StFetch, StFault} state_e;

    localparam logic [DATA_WIDTH:0] RomLo = {1'b0, RESET_PC};
    localparam logic [DATA_WIDTH:0] RomHi = {1'b0, RESET_PC} + (DATA_WIDTH + 1)'(4 * MEMORY_DEPTH);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] ifid_pc_q, ifid_pc_d;
    logic [DATA_WIDTH-1:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
    logic [DATA_WIDTH-1:0] ifid_instr_q, ifid_instr_d;
    logic                  ifid_valid_q, ifid_valid_d;
    logic                  fault_q, fault_d;
    logic [DATA_WIDTH-1:0] count_q, count_d;

    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [DATA_WIDTH-1:0] target;
    logic [DATA_WIDTH:0]   target_ext;
    logic                  target_legal;

    assign pc_plus4   = pc_q + DATA_WIDTH'(4);
    assign target     = redirect_i ? redirect_target_i : (stall_i ? pc_q : pc_plus4);
    // Zero-extended compare so a target near 2^32 cannot alias into the ROM window.
    assign target_ext = {1'b0, target};
    assign target_legal = (target[1:0] == 2'b00) && (target_ext >= RomLo) && (target_ext < RomHi);

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        ifid_pc_d       = ifid_pc_q;
        ifid_pc_plus4_d = ifid_pc_plus4_q;
        ifid_instr_d    = ifid_instr_q;
        ifid_valid_d    = ifid_valid_q;
        fault_d         = fault_q;
        count_d         = count_q;

        if (state_q == StFetch) begin
            if (target_legal) begin
                pc_d = target;
            end else begin
                fault_d = 1'b1;
                state_d = StFault;
            end

            if (redirect_i) begin
                ifid_instr_d = NOP_INSTR;
                ifid_valid_d = 1'b0;
            end else if (!stall_i) begin
                ifid_pc_d       = pc_q;
                ifid_pc_plus4_d = pc_plus4;
                ifid_instr_d    = instruction_i;
                ifid_valid_d    = 1'b1;
                count_d         = count_q + DATA_WIDTH'(1);
            end
        end else begin
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StFetch;
            pc_q            <= RESET_PC;
            ifid_pc_q       <= '0;
            ifid_pc_plus4_q <= '0;
            ifid_instr_q    <= NOP_INSTR;
            ifid_valid_q    <= 1'b0;
            fault_q         <= 1'b0;
            count_q         <= '0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            ifid_pc_q       <= ifid_pc_d;
            ifid_pc_plus4_q <= ifid_pc_plus4_d;
            ifid_instr_q    <= ifid_instr_d;
            ifid_valid_q    <= ifid_valid_d;
            fault_q         <= fault_d;
            count_q         <= count_d;
        end
    end

    assign pc_o               = pc_q;
    assign ifid_pc_o          = ifid_pc_q;
    assign ifid_pc_plus4_o    = ifid_pc_plus4_q;
    assign ifid_instruction_o = ifid_instr_q;
    assign ifid_valid_o       = ifid_valid_q;
    assign fetch_fault_o      = fault_q;
    assign fetch_count_o      = count_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage; the ROM model returns word = address.
module tb_instruction_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_target_i;
    logic [31:0] instruction_i;
    logic [31:0] pc_o;
    logic [31:0] ifid_pc_o;
    logic [31:0] ifid_pc_plus4_o;
    logic [31:0] ifid_instruction_o;
    logic        ifid_valid_o;
    logic        fetch_fault_o;
    logic [31:0] fetch_count_o;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] NOP = 32'h00000013;

    always #5 clk = ~clk;

    assign instruction_i = pc_o;

    instruction_fetch_stage dut (
        .clk                (clk),
        .reset              (reset),
        .stall_i            (stall_i),
        .redirect_i         (redirect_i),
        .redirect_target_i  (redirect_target_i),
        .instruction_i      (instruction_i),
        .pc_o               (pc_o),
        .ifid_pc_o          (ifid_pc_o),
        .ifid_pc_plus4_o    (ifid_pc_plus4_o),
        .ifid_instruction_o (ifid_instruction_o),
        .ifid_valid_o       (ifid_valid_o),
        .fetch_fault_o      (fetch_fault_o),
        .fetch_count_o      (fetch_count_o)
    );

    typedef struct {
        logic        rst;
        logic        stl;
        logic        rdr;
        logic [31:0] tgt;
        logic [31:0] e_pc;
        logic [31:0] e_ipc;
        logic [31:0] e_ip4;
        logic [31:0] e_ins;
        logic        e_v;
        logic        e_flt;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic stl, input logic rdr, input logic [31:0] tgt,
                       input logic [31:0] e_pc, input logic [31:0] e_ipc,
                       input logic [31:0] e_ip4, input logic [31:0] e_ins, input logic e_v,
                       input logic e_flt, input logic [31:0] e_cnt);
        vec_t v;
        v.rst = rst; v.stl = stl; v.rdr = rdr; v.tgt = tgt;
        v.e_pc = e_pc; v.e_ipc = e_ipc; v.e_ip4 = e_ip4; v.e_ins = e_ins;
        v.e_v = e_v; v.e_flt = e_flt; v.e_cnt = e_cnt;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input vec_t v);
        string s;
        s = $sformatf("v%0d", idx);
        check({s, ".pc"},    pc_o,               v.e_pc);
        check({s, ".ipc"},   ifid_pc_o,          v.e_ipc);
        check({s, ".ip4"},   ifid_pc_plus4_o,    v.e_ip4);
        check({s, ".ins"},   ifid_instruction_o, v.e_ins);
        check({s, ".valid"}, 32'(ifid_valid_o),  32'(v.e_v));
        check({s, ".fault"}, 32'(fetch_fault_o), 32'(v.e_flt));
        check({s, ".count"}, fetch_count_o,      v.e_cnt);
    endtask

    task automatic drive(input logic rst, input logic stl, input logic rdr, input logic [31:0] tgt);
        reset = rst; stall_i = stl; redirect_i = rdr; redirect_target_i = tgt;
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 32'h0);

        //  rst stl rdr target        pc            ifid_pc       plus4         instr         v  f  cnt
        add(1, 0, 0, 32'h0,        32'h00400000, 32'h0,        32'h0,        NOP,          0, 0, 0);
        add(0, 0, 0, 32'h0,        32'h00400004, 32'h00400000, 32'h00400004, 32'h00400000, 1, 0, 1);
        add(0, 0, 0, 32'h0,        32'h00400008, 32'h00400004, 32'h00400008, 32'h00400004, 1, 0, 2);
        add(0, 0, 0, 32'h0,        32'h0040000C, 32'h00400008, 32'h0040000C, 32'h00400008, 1, 0, 3);
        add(0, 0, 0, 32'h0,        32'h00400010, 32'h0040000C, 32'h00400010, 32'h0040000C, 1, 0, 4);
        add(1, 0, 0, 32'h0,        32'h00400000, 32'h0,        32'h0,        NOP,          0, 0, 0);
        add(0, 0, 0, 32'h0,        32'h00400004, 32'h00400000, 32'h00400004, 32'h00400000, 1, 0, 1);
        add(0, 0, 0, 32'h0,        32'h00400008, 32'h00400004, 32'h00400008, 32'h00400004, 1, 0, 2);
        add(0, 1, 0, 32'h0,        32'h00400008, 32'h00400004, 32'h00400008, 32'h00400004, 1, 0, 2);
        add(0, 1, 0, 32'h0,        32'h00400008, 32'h00400004, 32'h00400008, 32'h00400004, 1, 0, 2);
        add(0, 0, 0, 32'h0,        32'h0040000C, 32'h00400008, 32'h0040000C, 32'h00400008, 1, 0, 3);
        // redirect beats stall: flush, IF/ID pc fields hold
        add(0, 1, 1, 32'h00400040, 32'h00400040, 32'h00400008, 32'h0040000C, NOP,          0, 0, 3);
        add(0, 0, 0, 32'h0,        32'h00400044, 32'h00400040, 32'h00400044, 32'h00400040, 1, 0, 4);
        add(0, 0, 1, 32'h00400042, 32'h00400044, 32'h00400040, 32'h00400044, NOP,          0, 1, 4);
        add(0, 1, 1, 32'h00400000, 32'h00400044, 32'h00400040, 32'h00400044, NOP,          0, 1, 4);
        add(0, 0, 0, 32'h0,        32'h00400044, 32'h00400040, 32'h00400044, NOP,          0, 1, 4);
        add(1, 0, 0, 32'h0,        32'h00400000, 32'h0,        32'h0,        NOP,          0, 0, 0);
        add(0, 0, 1, 32'h004000F8, 32'h004000F8, 32'h0,        32'h0,        NOP,          0, 0, 0);
        add(0, 0, 0, 32'h0,        32'h004000FC, 32'h004000F8, 32'h004000FC, 32'h004000F8, 1, 0, 1);
        // step past last ROM word: last word still delivered, fault raised
        add(0, 0, 0, 32'h0,        32'h004000FC, 32'h004000FC, 32'h00400100, 32'h004000FC, 1, 1, 2);
        add(0, 0, 0, 32'h0,        32'h004000FC, 32'h004000FC, 32'h00400100, NOP,          0, 1, 2);
        add(1, 0, 0, 32'h0,        32'h00400000, 32'h0,        32'h0,        NOP,          0, 0, 0);
        add(0, 0, 0, 32'h0,        32'h00400004, 32'h00400000, 32'h00400004, 32'h00400000, 1, 0, 1);
        add(1, 0, 1, 32'h00400080, 32'h00400000, 32'h0,        32'h0,        NOP,          0, 0, 0);
        add(0, 0, 0, 32'h0,        32'h00400004, 32'h00400000, 32'h00400004, 32'h00400000, 1, 0, 1);
        add(0, 0, 1, 32'h003FFFFC, 32'h00400004, 32'h00400000, 32'h00400004, NOP,          0, 1, 1);
        add(1, 0, 0, 32'h0,        32'h00400000, 32'h0,        32'h0,        NOP,          0, 0, 0);
        add(0, 0, 1, 32'hFFFFFFFC, 32'h00400000, 32'h0,        32'h0,        NOP,          0, 1, 0);
        add(1, 0, 0, 32'h0,        32'h00400000, 32'h0,        32'h0,        NOP,          0, 0, 0);
        add(0, 0, 1, 32'h00400100, 32'h00400000, 32'h0,        32'h0,        NOP,          0, 1, 0);
        add(1, 0, 0, 32'h0,        32'h00400000, 32'h0,        32'h0,        NOP,          0, 0, 0);
        add(0, 0, 1, 32'h004000FC, 32'h004000FC, 32'h0,        32'h0,        NOP,          0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].stl, vecs[i].rdr, vecs[i].tgt);
            @(posedge clk);
            #1;
            check_all(i, vecs[i]);
        end

        // pc_o must not respond combinationally to redirect/stall between edges
        drive(1'b0, 1'b1, 1'b1, 32'h00400020);
        #2;
        check("comb.pc", pc_o, 32'h004000FC);

        // long free run: counter and PC track edge count
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
        end
        check("run.pc",    pc_o,            32'h00400050);
        check("run.count", fetch_count_o,   32'd20);
        check("run.ipc",   ifid_pc_o,       32'h0040004C);
        check("run.valid", 32'(ifid_valid_o), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
